microsequencer: RTL and testbench

MICROSEQUENCER -- requirements
Module: microsequencer

---
 rtl/microsequencer.sv | 133 +++++++++++++
 tb/tb_microsequencer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/microsequencer.sv
// Microsequencer: selects the next microstore address from decode, fetch,
// jump, increment, conditional branch/wait and a bounded call/return stack.
module microsequencer #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] current_state,
    input  logic [2:0]        ns_sel,
    input  logic [1:0]        cond_sel,
    input  logic              inv,
    input  logic [ADDR_W-1:0] cr,
    input  logic [ADDR_W-1:0] decoder_state,
    input  logic              moc,
    input  logic              cond_flag,
    input  logic              cond_alt,
    output logic [ADDR_W-1:0] next_state,
    output logic [2:0]        stack_depth,
    output logic              stack_err
);

    localparam int unsigned DEPTH_W = 3;
    localparam logic [DEPTH_W-1:0] FULL_DEPTH = DEPTH_W'(STACK_DEPTH);

    typedef enum logic [2:0] {
        NS_DECODE = 3'b000,
        NS_FETCH  = 3'b001,
        NS_JUMP   = 3'b010,
        NS_INC    = 3'b011,
        NS_BRANCH = 3'b100,
        NS_WAIT   = 3'b101,
        NS_CALL   = 3'b110,
        NS_RETURN = 3'b111
    } ns_sel_e;

    typedef enum logic [1:0] {
        CS_MOC  = 2'b00,
        CS_FLAG = 2'b01,
        CS_ALT  = 2'b10,
        CS_ONE  = 2'b11
    } cond_sel_e;

    logic [ADDR_W-1:0]  stack_mem [STACK_DEPTH];
    logic               src_c;
    logic               cond_c;
    logic [ADDR_W-1:0]  inc_c;
    logic [ADDR_W-1:0]  top_c;
    logic [ADDR_W-1:0]  ns_d;
    logic [DEPTH_W-1:0] depth_d;
    logic               err_d;
    logic               push_c;

    // Only the selected source reaches cond, so unknowns elsewhere cannot leak in.
    always_comb begin
        src_c = 1'b0;
        case (cond_sel)
            CS_MOC:  src_c = moc;
            CS_FLAG: src_c = cond_flag;
            CS_ALT:  src_c = cond_alt;
            CS_ONE:  src_c = 1'b1;
            default: src_c = 1'b0;
        endcase
        cond_c = src_c ^ inv;
        inc_c  = current_state + ADDR_W'(1);
    end

    // Top-of-stack read: entry at index depth-1.
    always_comb begin
        top_c = '0;
        for (int i = 0; i < int'(STACK_DEPTH); i++) begin
            if (stack_depth == DEPTH_W'(i + 1)) begin
                top_c = stack_mem[i];
            end
        end
    end

    // Next-address selection and stack bookkeeping.
    always_comb begin
        ns_d    = next_state;
        depth_d = stack_depth;
        err_d   = stack_err;
        push_c  = 1'b0;
        case (ns_sel)
            NS_DECODE: ns_d = decoder_state;
            NS_FETCH:  ns_d = '0;
            NS_JUMP:   ns_d = cr;
            NS_INC:    ns_d = inc_c;
            NS_BRANCH: ns_d = cond_c ? cr : inc_c;
            NS_WAIT:   ns_d = cond_c ? inc_c : current_state;
            NS_CALL: begin
                ns_d = cr;
                if (stack_depth == FULL_DEPTH) begin
                    err_d = 1'b1;
                end else begin
                    push_c  = 1'b1;
                    depth_d = stack_depth + DEPTH_W'(1);
                end
            end
            NS_RETURN: begin
                if (stack_depth == '0) begin
                    ns_d  = '0;
                    err_d = 1'b1;
                end else begin
                    ns_d    = top_c;
                    depth_d = stack_depth - DEPTH_W'(1);
                end
            end
            default: ns_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            next_state  <= '0;
            stack_depth <= '0;
            stack_err   <= 1'b0;
            for (int i = 0; i < int'(STACK_DEPTH); i++) begin
                stack_mem[i] <= '0;
            end
        end else begin
            next_state  <= ns_d;
            stack_depth <= depth_d;
            stack_err   <= err_d;
            for (int i = 0; i < int'(STACK_DEPTH); i++) begin
                if (push_c && stack_depth == DEPTH_W'(i)) begin
                    stack_mem[i] <= inc_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_microsequencer.sv
// Bench for microsequencer: directed scenarios plus random control words
// checked against a queue-based reference model.
module tb_microsequencer;

    localparam int AW    = 10;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] current_state;
    logic [2:0]    ns_sel;
    logic [1:0]    cond_sel;
    logic          inv;
    logic [AW-1:0] cr;
    logic [AW-1:0] decoder_state;
    logic          moc, cond_flag, cond_alt;
    logic [AW-1:0] next_state;
    logic [2:0]    stack_depth;
    logic          stack_err;

    int total = 0;
    int bad   = 0;

    int exp_ns  = 0;
    int exp_err = 0;
    int stk[$];

    microsequencer #(.ADDR_W(AW), .STACK_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .current_state(current_state),
        .ns_sel(ns_sel), .cond_sel(cond_sel), .inv(inv), .cr(cr),
        .decoder_state(decoder_state), .moc(moc), .cond_flag(cond_flag),
        .cond_alt(cond_alt), .next_state(next_state),
        .stack_depth(stack_depth), .stack_err(stack_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".ns"},    32'(next_state),  32'(exp_ns));
        chk({tag, ".depth"}, 32'(stack_depth), 32'(stk.size()));
        chk({tag, ".err"},   32'(stack_err),   32'(exp_err));
    endtask

    // Reference: evaluate the control word with plain arithmetic, advance one edge, compare.
    task automatic cycle(input string tag, input int ns, input int cur, input int crv,
                         input int dec, input int cs, input bit iv,
                         input logic m, input logic cf, input logic ca);
        logic srcs [4];
        bit   cnd;
        int   inc;
        current_state = AW'(cur);
        ns_sel        = 3'(ns);
        cr            = AW'(crv);
        decoder_state = AW'(dec);
        cond_sel      = 2'(cs);
        inv           = iv;
        moc           = m;
        cond_flag     = cf;
        cond_alt      = ca;
        srcs = '{m, cf, ca, 1'b1};
        cnd  = (srcs[cs] == 1'b1) != iv;
        inc  = (cur + 1) % (1 << AW);
        case (ns)
            0: exp_ns = dec;
            1: exp_ns = 0;
            2: exp_ns = crv;
            3: exp_ns = inc;
            4: exp_ns = cnd ? crv : inc;
            5: exp_ns = cnd ? inc : cur;
            6: begin
                exp_ns = crv;
                if (stk.size() == DEPTH) exp_err = 1;
                else stk.push_back(inc);
            end
            default: begin
                if (stk.size() == 0) begin
                    exp_ns  = 0;
                    exp_err = 1;
                end else begin
                    exp_ns = stk.pop_back();
                end
            end
        endcase
        @(posedge clk);
        #1;
        chk_all(tag);
    endtask

    task automatic model_reset();
        exp_ns  = 0;
        exp_err = 0;
        stk.delete();
    endtask

    // Reset asserted mid-cycle, observed before any edge, held across one edge.
    task automatic do_reset(input string tag);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk_all({tag, ".async"});
        @(posedge clk);
        #1;
        chk_all({tag, ".held"});
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        current_state = '0; ns_sel = 3'b011; cond_sel = '0; inv = 1'b0;
        cr = '0; decoder_state = '0; moc = 1'b0; cond_flag = 1'b0; cond_alt = 1'b0;
        model_reset();
        #3;
        chk_all("rst0");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Increment and wrap
        cycle("inc0", 3, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle("wrap", 3, 1023, 0, 0, 0, 0, 0, 0, 0);

        // Hold on moc, then release
        for (int i = 0; i < 5; i++) cycle("hold", 5, 3, 0, 0, 0, 0, 1'b0, 0, 0);
        cycle("hold_rel", 5, 3, 0, 0, 0, 0, 1'b1, 0, 0);

        // Conditional branch
        cycle("br_t",   4, 12, 20, 0, 1, 0, 0, 1, 0);
        cycle("br_inv", 4, 12, 20, 0, 1, 1, 0, 1, 0);
        cycle("br_one", 4, 12, 20, 0, 3, 0, 0, 0, 0);
        cycle("decode", 0, 12, 20, 777, 0, 0, 0, 0, 0);
        cycle("fetch",  1, 12, 20, 777, 0, 0, 0, 0, 0);
        cycle("jump",   2, 12, 99, 0, 0, 0, 0, 0, 0);

        // Nested calls and LIFO returns
        for (int i = 0; i < 4; i++) cycle("call", 6, 5 + 2 * i, 40, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle("ret", 7, 40, 0, 0, 0, 0, 0, 0, 0);

        // Overflow, drain, underflow
        for (int i = 0; i < 4; i++) cycle("fill", 6, 100 + i, 40, 0, 0, 0, 0, 0, 0);
        cycle("ovf", 6, 200, 40, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle("drain", 7, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle("unf", 7, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle("sticky", 3, 55, 0, 0, 0, 0, 0, 0, 0);

        do_reset("rst1");

        // Reset in the middle of a wait with a partly filled stack
        cycle("pre_c", 6, 30, 60, 0, 0, 0, 0, 0, 0);
        cycle("hold2", 5, 8, 0, 0, 2, 0, 0, 0, 1'b0);
        do_reset("rst_hold");
        cycle("post", 7, 0, 0, 0, 0, 0, 0, 0, 0);
        do_reset("rst2");

        // Random control words; unselected sources sometimes driven X
        for (int n = 0; n < 400; n++) begin
            int   ns, cs;
            logic m, cf, ca;
            ns = int'($urandom_range(7, 0));
            cs = int'($urandom_range(3, 0));
            m  = 1'($urandom);
            cf = 1'($urandom);
            ca = 1'($urandom);
            if (cs != 0 && $urandom_range(1, 0) == 1) m  = 1'bx;
            if (cs != 1 && $urandom_range(1, 0) == 1) cf = 1'bx;
            if (cs != 2 && $urandom_range(1, 0) == 1) ca = 1'bx;
            cycle("rnd", ns, int'($urandom_range(1023, 0)), int'($urandom_range(1023, 0)),
                  int'($urandom_range(1023, 0)), cs, 1'($urandom), m, cf, ca);
            if (n == 200) do_reset("rst_rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
